// File: rtl/input_pkg.sv
// input_pkg: shared types and defaults for the push-button conditioning logic.
package input_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        ARM_PRESS,
        PRESSED,
        ARM_RELEASE
    } debounce_state_t;

    localparam int DEFAULT_STABLE_CYCLES = 16;

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: synchronises, polarity-corrects and qualifies one raw button bit.
module debounce_channel
    import input_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic pressed_o,
    output logic pulse_o
);
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    debounce_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0] sync_q;
    logic pulse_q, pulse_d;
    logic s;

    // s is 1 while the synchronised pin reads "pressed", whatever the board polarity
    assign s = sync_q[1] ^ ACTIVE_LOW;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= {2{ACTIVE_LOW}};
            state_q <= RELEASED;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        unique case (state_q)
            RELEASED: begin
                if (s) begin
                    state_d = ARM_PRESS;
                    cnt_d   = CW'(1);
                end
            end
            ARM_PRESS: begin
                if (!s) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = ARM_RELEASE;
                    cnt_d   = CW'(1);
                end
            end
            ARM_RELEASE: begin
                if (s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    assign pressed_o = (state_q == PRESSED) || (state_q == ARM_RELEASE);
    assign pulse_o   = pulse_q;

endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: NUM_BTN independent debounced button channels with press strobes.
module button_debouncer
    import input_pkg::*;
#(
    parameter int NUM_BTN       = 4,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_pressed,
    output logic [NUM_BTN-1:0] press_pulse
);
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .raw_i    (btn_raw[i]),
            .pressed_o(btn_pressed[i]),
            .pulse_o  (press_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed and random checks against a run-length reference model.
module tb_button_debouncer;
    localparam int N = 2;
    localparam int S = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0] btn_raw = '1;
    logic [N-1:0] btn_pressed, press_pulse;

    int checks = 0;
    int errors = 0;
    int pulses[N];
    logic [N-1:0] m_lvl = '0, m_pulse = '0, m_h1 = '0, m_h2 = '0;
    int m_run[N];

    always #5 clk = ~clk;

    button_debouncer #(.NUM_BTN(N), .STABLE_CYCLES(S), .ACTIVE_LOW(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .btn_pressed(btn_pressed),
        .press_pulse(press_pulse)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: level flips once S consecutive synced samples disagree with it; synced = pressed 2 edges late
    task automatic tick(input logic [N-1:0] raw);
        btn_raw = raw;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            m_pulse[i] = 1'b0;
            if (reset) begin
                m_lvl[i] = 1'b0;
                m_run[i] = 0;
                m_h1[i]  = 1'b0;
                m_h2[i]  = 1'b0;
            end else begin
                m_run[i] = (m_h2[i] == m_lvl[i]) ? 0 : m_run[i] + 1;
                if (m_run[i] == S) begin
                    m_lvl[i]   = ~m_lvl[i];
                    m_run[i]   = 0;
                    m_pulse[i] = m_lvl[i];
                end
                m_h2[i] = m_h1[i];
                m_h1[i] = ~raw[i];
            end
        end
        #1;
        check("model_pressed", 32'(btn_pressed), 32'(m_lvl));
        check("model_pulse", 32'(press_pulse), 32'(m_pulse));
        for (int i = 0; i < N; i++) pulses[i] += int'(press_pulse[i]);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            pulses[i] = 0;
            m_run[i]  = 0;
        end
        reset = 1'b1;
        tick(2'b11);
        tick(2'b11);
        check("reset_pressed", 32'(btn_pressed), 32'h0);
        check("reset_pulse", 32'(press_pulse), 32'h0);
        reset = 1'b0;
        repeat (3) tick(2'b11);
        check("idle_pressed", 32'(btn_pressed), 32'h0);
        repeat (5) tick(2'b10);
        check("press_before_6", 32'(btn_pressed), 32'h0);
        tick(2'b10);
        check("press_at_6", 32'(btn_pressed), 32'h1);
        check("pulse_at_6", 32'(press_pulse), 32'h1);
        tick(2'b10);
        check("pulse_one_cycle", 32'(press_pulse), 32'h0);
        repeat (3) tick(2'b10);
        check("press_pulse_count0", 32'(pulses[0]), 32'd1);
        check("ch1_untouched", 32'(pulses[1]), 32'd0);
        repeat (8) tick(2'b11);
        check("released", 32'(btn_pressed), 32'h0);
        repeat (3) tick(2'b10);
        repeat (6) tick(2'b11);
        check("short_press_level", 32'(btn_pressed), 32'h0);
        check("short_press_pulses", 32'(pulses[0]), 32'd1);
        repeat (8) tick(2'b10);
        check("held_again", 32'(btn_pressed), 32'h1);
        repeat (2) tick(2'b11);
        repeat (6) tick(2'b10);
        check("glitch_level", 32'(btn_pressed), 32'h1);
        check("glitch_pulses", 32'(pulses[0]), 32'd2);
        repeat (5) tick(2'b11);
        check("release_before_6", 32'(btn_pressed), 32'h1);
        tick(2'b11);
        check("release_at_6", 32'(btn_pressed), 32'h0);
        repeat (2) tick(2'b11);
        repeat (5) tick(2'b00);
        check("both_before_6", 32'(btn_pressed), 32'h0);
        tick(2'b00);
        check("both_at_6", 32'(btn_pressed), 32'h3);
        check("both_pulse", 32'(press_pulse), 32'h3);
        repeat (3) tick(2'b00);
        check("both_pulses0", 32'(pulses[0]), 32'd3);
        check("both_pulses1", 32'(pulses[1]), 32'd1);
        reset = 1'b1;
        tick(2'b00);
        check("mid_reset_pressed", 32'(btn_pressed), 32'h0);
        check("mid_reset_pulse", 32'(press_pulse), 32'h0);
        tick(2'b00);
        reset = 1'b0;
        repeat (5) tick(2'b00);
        check("requalify_before_6", 32'(btn_pressed), 32'h0);
        tick(2'b00);
        check("requalify_at_6", 32'(btn_pressed), 32'h3);
        check("requalify_pulse", 32'(press_pulse), 32'h3);
        repeat (3) tick(2'b00);
        check("requalify_pulses0", 32'(pulses[0]), 32'd4);
        check("requalify_pulses1", 32'(pulses[1]), 32'd2);
        repeat (8) tick(2'b11);
        for (int k = 0; k < 600; k++) begin
            reset = ($urandom_range(0, 249) == 0);
            tick(btn_raw ^ {N'($urandom_range(0, 5) == 0), N'($urandom_range(0, 5) == 0)} [N-1:0]);
        end
        reset = 1'b0;
        repeat (10) tick(2'b11);
        check("final_released", 32'(btn_pressed), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
